// File: rtl/mem_stage_mq_if.sv
// EX/WB/data-sram facing signal bundle of the multi-outstanding MEM stage.
// master = surrounding pipeline and memory, slave = the MEM stage itself.
interface mem_stage_mq_if #(
   parameter int PAYLOAD_W = 64
);
   logic                 es_to_ms_valid;
   logic                 ms_allowin;
   logic                 es_mem_req;
   logic [2:0]           es_ld_type;
   logic [1:0]           es_ldb;
   logic [31:0]          es_rt;
   logic [31:0]          es_result;
   logic                 es_res_from_mem;
   logic                 es_gr_we;
   logic [4:0]           es_dest;
   logic [PAYLOAD_W-1:0] es_payload;
   logic                 data_sram_data_ok;
   logic [31:0]          data_sram_rdata;
   logic                 flush;
   logic                 ws_allowin;
   logic                 ms_to_ws_valid;
   logic [31:0]          ms_to_ws_result;
   logic                 ms_to_ws_gr_we;
   logic [4:0]           ms_to_ws_dest;
   logic [PAYLOAD_W-1:0] ms_to_ws_payload;
   logic [31:0]          ms_dest_mask;
   logic                 ms_load_pending;
   logic                 ms_fwd_valid;

   modport master (
      output es_to_ms_valid, es_mem_req, es_ld_type, es_ldb, es_rt, es_result,
             es_res_from_mem, es_gr_we, es_dest, es_payload,
             data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
      input  ms_allowin, ms_to_ws_valid, ms_to_ws_result, ms_to_ws_gr_we,
             ms_to_ws_dest, ms_to_ws_payload, ms_dest_mask, ms_load_pending, ms_fwd_valid
   );

   modport slave (
      input  es_to_ms_valid, es_mem_req, es_ld_type, es_ldb, es_rt, es_result,
             es_res_from_mem, es_gr_we, es_dest, es_payload,
             data_sram_data_ok, data_sram_rdata, flush, ws_allowin,
      output ms_allowin, ms_to_ws_valid, ms_to_ws_result, ms_to_ws_gr_we,
             ms_to_ws_dest, ms_to_ws_payload, ms_dest_mask, ms_load_pending, ms_fwd_valid
   );
endinterface

// File: rtl/mem_stage_mq.sv
// MEM stage holding up to DEPTH in-order instructions with multiple outstanding
// data-sram requests, load-data extraction and flush-cancel of stale responses.
module mem_stage_mq #(
   parameter int DEPTH     = 2,
   parameter int PAYLOAD_W = 64
) (
   input  logic         clk,
   input  logic         resetn,
   mem_stage_mq_if.slave ms
);
   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = $clog2(DEPTH + 1);
   localparam int SUM_W   = CNT_W + 2;
   localparam int CAN_MAX = DEPTH + 1;

   // per-entry control state (async reset) and storage (no reset)
   logic [DEPTH-1:0]     v_reg, mem_reg, got_reg;
   logic [DEPTH-1:0]     rfm_reg, gr_we_reg;
   logic [2:0]           ld_type_mem [DEPTH];
   logic [1:0]           ldb_mem     [DEPTH];
   logic [31:0]          rt_mem      [DEPTH];
   logic [31:0]          result_mem  [DEPTH];
   logic [31:0]          rdata_mem   [DEPTH];
   logic [4:0]           dest_mem    [DEPTH];
   logic [PAYLOAD_W-1:0] payload_mem [DEPTH];

   logic [PTR_W-1:0]     head_reg, tail_reg;
   logic [CNT_W-1:0]     count_reg, cancel_reg, cancel_next;

   logic [DEPTH-1:0]     pend, ld_wait;
   logic [31:0]          dm_bits [DEPTH];
   logic [31:0]          mask_acc;
   logic [PTR_W-1:0]     resp_idx, scan_idx;
   logic                 resp_any, resp_live;
   logic [SUM_W-1:0]     pend_cnt, cancel_sum;
   logic                 head_v, head_ready, head_bypass;
   logic [31:0]          head_data, head_value;
   logic                 retire, enq, ms_valid;

   function automatic logic [31:0] load_extract(
      input logic [2:0]  ld_type,
      input logic [1:0]  ldb,
      input logic [31:0] d,
      input logic [31:0] rt
   );
      logic [7:0]  byte_sel;
      logic [15:0] half_sel;
      logic [31:0] res;
      byte_sel = d[{ldb, 3'b000} +: 8];
      half_sel = ldb[1] ? d[31:16] : d[15:0];
      case (ld_type)
         3'd1: res = {{24{byte_sel[7]}}, byte_sel};
         3'd2: res = {24'd0, byte_sel};
         3'd3: res = {{16{half_sel[15]}}, half_sel};
         3'd4: res = {16'd0, half_sel};
         3'd5: begin
            case (ldb)
               2'd0:    res = {d[7:0],  rt[23:0]};
               2'd1:    res = {d[15:0], rt[15:0]};
               2'd2:    res = {d[23:0], rt[7:0]};
               default: res = d;
            endcase
         end
         3'd6: begin
            case (ldb)
               2'd0:    res = d;
               2'd1:    res = {rt[31:24], d[31:8]};
               2'd2:    res = {rt[31:16], d[31:16]};
               default: res = {rt[31:8],  d[31:24]};
            endcase
         end
         default: res = d;
      endcase
      return res;
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         assign pend[gi]    = v_reg[gi] & mem_reg[gi] & ~got_reg[gi];
         assign ld_wait[gi] = v_reg[gi] & rfm_reg[gi] & ~got_reg[gi];
         assign dm_bits[gi] = (v_reg[gi] && gr_we_reg[gi]) ? (32'd1 << dest_mem[gi]) : 32'd0;
      end
   endgenerate

   // oldest entry still waiting for its response, scanning from the head
   always_comb begin
      resp_idx = head_reg;
      scan_idx = head_reg;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         scan_idx = head_reg + PTR_W'(k);
         if (pend[scan_idx]) resp_idx = scan_idx;
      end
   end

   assign resp_any  = |pend;
   assign resp_live = ms.data_sram_data_ok && (cancel_reg == '0) && resp_any;

   assign head_v      = v_reg[head_reg];
   assign head_bypass = ms.data_sram_data_ok && (cancel_reg == '0) && pend[head_reg];
   assign head_ready  = head_v && (!mem_reg[head_reg] || got_reg[head_reg] || head_bypass);
   assign head_data   = got_reg[head_reg] ? rdata_mem[head_reg] : ms.data_sram_rdata;
   assign head_value  = rfm_reg[head_reg]
                      ? load_extract(ld_type_mem[head_reg], ldb_mem[head_reg], head_data, rt_mem[head_reg])
                      : result_mem[head_reg];

   assign ms_valid = head_ready && !ms.flush;
   assign retire   = ms_valid && ms.ws_allowin;
   assign enq      = ms.es_to_ms_valid && ms.ms_allowin;

   assign ms.ms_allowin       = resetn && !ms.flush && ((count_reg < CNT_W'(DEPTH)) || retire);
   assign ms.ms_to_ws_valid   = ms_valid;
   assign ms.ms_fwd_valid     = ms_valid;
   assign ms.ms_to_ws_result  = head_v ? head_value : 32'd0;
   assign ms.ms_to_ws_gr_we   = head_v && gr_we_reg[head_reg];
   assign ms.ms_to_ws_dest    = head_v ? dest_mem[head_reg] : 5'd0;
   assign ms.ms_to_ws_payload = head_v ? payload_mem[head_reg] : '0;
   assign ms.ms_load_pending  = |ld_wait;

   always_comb begin
      mask_acc = '0;
      for (int i = 0; i < DEPTH; i++) mask_acc = mask_acc | dm_bits[i];
   end
   assign ms.ms_dest_mask = {mask_acc[31:1], 1'b0};

   // on flush every unanswered request, including one issued by EX this cycle, becomes a cancel
   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < DEPTH; i++) pend_cnt = pend_cnt + SUM_W'(pend[i]);
      cancel_sum = SUM_W'(cancel_reg) + pend_cnt + SUM_W'(ms.es_to_ms_valid && ms.es_mem_req);
      if (ms.data_sram_data_ok && (cancel_sum != '0)) cancel_sum = cancel_sum - SUM_W'(1);
      cancel_next = cancel_reg;
      if (ms.flush)
         cancel_next = (cancel_sum > SUM_W'(CAN_MAX)) ? CNT_W'(CAN_MAX) : cancel_sum[CNT_W-1:0];
      else if (ms.data_sram_data_ok && (cancel_reg != '0))
         cancel_next = cancel_reg - CNT_W'(1);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v_reg      <= '0;
         mem_reg    <= '0;
         got_reg    <= '0;
         head_reg   <= '0;
         tail_reg   <= '0;
         count_reg  <= '0;
         cancel_reg <= '0;
      end else begin
         cancel_reg <= cancel_next;
         if (ms.flush) begin
            v_reg     <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
         end else begin
            if (resp_live) got_reg[resp_idx] <= 1'b1;
            if (retire) begin
               v_reg[head_reg] <= 1'b0;
               head_reg        <= head_reg + PTR_W'(1);
            end
            if (enq) begin
               v_reg[tail_reg]   <= 1'b1;
               mem_reg[tail_reg] <= ms.es_mem_req;
               got_reg[tail_reg] <= 1'b0;
               tail_reg          <= tail_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(enq) - CNT_W'(retire);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         ld_type_mem[tail_reg] <= ms.es_ld_type;
         ldb_mem[tail_reg]     <= ms.es_ldb;
         rt_mem[tail_reg]      <= ms.es_rt;
         result_mem[tail_reg]  <= ms.es_result;
         rfm_reg[tail_reg]     <= ms.es_res_from_mem;
         gr_we_reg[tail_reg]   <= ms.es_gr_we;
         dest_mem[tail_reg]    <= ms.es_dest;
         payload_mem[tail_reg] <= ms.es_payload;
      end
      if (resp_live) rdata_mem[resp_idx] <= ms.data_sram_rdata;
   end

`ifndef SYNTHESIS
   a_cancel_bound: assert property (@(posedge clk) disable iff (!resetn)
      !(ms.flush && (cancel_sum > SUM_W'(CAN_MAX))));
   a_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
      !(ms.data_sram_data_ok && (cancel_reg == '0) && !resp_any));
`endif
endmodule

// File: tb/tb_mem_stage_mq.sv
// Scoreboarded bench for mem_stage_mq: expected retirements are queued at issue
// and compared when the stage hands an instruction to WB.
module tb_mem_stage_mq;
   logic clk;
   logic resetn;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  dest;
      logic [63:0] payload;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   mem_stage_mq_if #(.PAYLOAD_W(64)) bus ();
   mem_stage_mq #(.DEPTH(2), .PAYLOAD_W(64)) dut (.clk(clk), .resetn(resetn), .ms(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_result(input logic [2:0] t, input logic [1:0] b,
         input logic [31:0] d, input logic [31:0] rt, input logic [31:0] alu, input logic rfm);
      logic [31:0] sh;
      logic [31:0] ones;
      int s;
      ones = 32'hFFFF_FFFF;
      s = 8 * int'(b);
      sh = d >> s;
      if (!rfm) return alu;
      case (t)
         3'd1: return {{24{sh[7]}}, sh[7:0]};
         3'd2: return {24'd0, sh[7:0]};
         3'd3: begin sh = b[1] ? (d >> 16) : d; return {{16{sh[15]}}, sh[15:0]}; end
         3'd4: begin sh = b[1] ? (d >> 16) : d; return {16'd0, sh[15:0]}; end
         3'd5: return (d << (24 - s)) | (rt & (ones >> (s + 8)));
         3'd6: return (d >> s) | (rt & ~(ones >> s));
         default: return d;
      endcase
   endfunction

   // retirement monitor: pops the scoreboard on every accepted WB handoff
   always @(negedge clk) begin
      if (resetn && bus.ms_to_ws_valid && bus.ws_allowin) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL retire_unexpected: got result=%h dest=%0d, required no retirement",
                     bus.ms_to_ws_result, bus.ms_to_ws_dest);
         end else begin
            mon_e = sb.pop_front();
            if (bus.ms_to_ws_result !== mon_e.res || bus.ms_to_ws_dest !== mon_e.dest ||
                bus.ms_to_ws_gr_we !== 1'b1 || bus.ms_to_ws_payload !== mon_e.payload) begin
               errors++;
               $display("FAIL retire_data: got res=%h dest=%0d we=%b pl=%h, required res=%h dest=%0d we=1 pl=%h",
                        bus.ms_to_ws_result, bus.ms_to_ws_dest, bus.ms_to_ws_gr_we, bus.ms_to_ws_payload,
                        mon_e.res, mon_e.dest, mon_e.payload);
            end else begin
               $display("retire res=%h dest=%0d", bus.ms_to_ws_result, bus.ms_to_ws_dest);
            end
         end
      end
   end

   // starts and ends at posedge+1; enqueues one instruction, optionally expecting it to retire
   task automatic issue(input logic [2:0] t, input logic [1:0] b, input logic [31:0] rt,
         input logic rfm, input logic mreq, input logic [4:0] dest, input logic [31:0] planned, input bit keep);
      exp_t e;
      bit acc;
      acc = 0;
      bus.es_to_ms_valid  = 1'b1;
      bus.es_ld_type      = t;
      bus.es_ldb          = b;
      bus.es_rt           = rt;
      bus.es_result       = $urandom;
      bus.es_res_from_mem = rfm;
      bus.es_mem_req      = mreq;
      bus.es_gr_we        = 1'b1;
      bus.es_dest         = dest;
      bus.es_payload      = {$urandom, $urandom};
      for (int n = 0; n < 20 && !acc; n++) begin
         #1;
         if (bus.ms_allowin === 1'b1) acc = 1;
         else begin @(posedge clk); #1; end
      end
      checks++;
      if (!acc) begin
         errors++;
         $display("FAIL issue_timeout: got ms_allowin=0 for 20 cycles, required 1");
      end else if (keep) begin
         e.res = ref_result(t, b, planned, rt, bus.es_result, rfm);
         e.dest = dest;
         e.payload = bus.es_payload;
         sb.push_back(e);
         $display("issue type=%0d ldb=%0d dest=%0d expect=%h", t, b, dest, e.res);
      end else begin
         $display("issue type=%0d ldb=%0d dest=%0d (to be killed)", t, b, dest);
      end
      @(posedge clk); #1;
      bus.es_to_ms_valid = 1'b0;
   endtask

   task automatic run_load(input logic [2:0] t, input logic [1:0] b, input logic [31:0] rt,
         input logic [31:0] d, input logic [4:0] dest);
      issue(t, b, rt, 1'b1, 1'b1, dest, d, 1);
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = d;
      #1;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b1) begin
         errors++;
         $display("FAIL bypass_valid: got %b, required 1", bus.ms_to_ws_valid);
      end
      @(posedge clk); #1;
      bus.data_sram_data_ok = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (bus.ms_allowin !== 1'b0 || bus.ms_to_ws_valid !== 1'b0 || bus.ms_fwd_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: got allowin=%b valid=%b fwd=%b, required 0 0 0",
                  bus.ms_allowin, bus.ms_to_ws_valid, bus.ms_fwd_valid);
      end
      checks++;
      if ({bus.ms_to_ws_result, bus.ms_to_ws_dest, bus.ms_to_ws_gr_we, bus.ms_to_ws_payload} !== '0) begin
         errors++;
         $display("FAIL reset_head: got res=%h dest=%0d we=%b pl=%h, required all 0",
                  bus.ms_to_ws_result, bus.ms_to_ws_dest, bus.ms_to_ws_gr_we, bus.ms_to_ws_payload);
      end
      checks++;
      if (bus.ms_dest_mask !== 32'd0 || bus.ms_load_pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_hazard: got mask=%h pend=%b, required 0 0", bus.ms_dest_mask, bus.ms_load_pending);
      end
      @(posedge clk); #1;
      resetn = 1'b1;
      #1;
      checks++;
      if (bus.ms_allowin !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_allowin: got %b, required 1", bus.ms_allowin);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_lw_bypass();
      issue(3'd0, 2'd0, 32'h0, 1'b1, 1'b1, 5'd3, 32'h8765_4321, 1);
      #1;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_load_pending !== 1'b1 || bus.ms_dest_mask !== 32'h8) begin
         errors++;
         $display("FAIL lw_wait: got valid=%b pend=%b mask=%h, required 0 1 00000008",
                  bus.ms_to_ws_valid, bus.ms_load_pending, bus.ms_dest_mask);
      end
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h8765_4321;
      #1;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_to_ws_result !== 32'h8765_4321 || bus.ms_fwd_valid !== 1'b1) begin
         errors++;
         $display("FAIL lw_same_cycle: got valid=%b res=%h fwd=%b, required 1 87654321 1",
                  bus.ms_to_ws_valid, bus.ms_to_ws_result, bus.ms_fwd_valid);
      end
      @(posedge clk); #1;
      bus.data_sram_data_ok = 1'b0;
      #1;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b0 || bus.ms_dest_mask !== 32'd0) begin
         errors++;
         $display("FAIL lw_drained: got valid=%b mask=%h, required 0 0", bus.ms_to_ws_valid, bus.ms_dest_mask);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ld_types();
      run_load(3'd1, 2'd3, 32'h0, 32'h8012_3456, 5'd7);
      run_load(3'd2, 2'd3, 32'h0, 32'h8012_3456, 5'd8);
      run_load(3'd3, 2'd2, 32'h0, 32'h8001_1234, 5'd9);
      run_load(3'd4, 2'd0, 32'h0, 32'h1234_F00D, 5'd10);
      run_load(3'd1, 2'd1, 32'h0, 32'h0000_7F00, 5'd11);
      run_load(3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 5'd12);
      run_load(3'd6, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 5'd13);
      run_load(3'd5, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 5'd14);
      run_load(3'd6, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 5'd15);
      run_load(3'd7, 2'd2, 32'h0, 32'hCAFE_0001, 5'd16);
      issue(3'd0, 2'd0, 32'h0, 1'b0, 1'b0, 5'd17, 32'h0, 1);
      repeat (2) @(posedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL ld_types_drain: got %0d outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_back_to_back();
      bus.ws_allowin = 1'b0;
      issue(3'd0, 2'd0, 32'h0, 1'b1, 1'b1, 5'd5, 32'h1111_AAAA, 1);
      issue(3'd1, 2'd0, 32'h0, 1'b1, 1'b1, 5'd6, 32'h2222_BB85, 1);
      #1;
      checks++;
      if (bus.ms_allowin !== 1'b0 || bus.ms_dest_mask !== 32'h60) begin
         errors++;
         $display("FAIL full_block: got allowin=%b mask=%h, required 0 00000060", bus.ms_allowin, bus.ms_dest_mask);
      end
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h1111_AAAA;
      @(posedge clk); #1;
      bus.data_sram_rdata   = 32'h2222_BB85;
      #1;
      checks++;
      if (bus.ms_to_ws_valid !== 1'b1 || bus.ms_to_ws_result !== 32'h1111_AAAA || bus.ms_allowin !== 1'b0) begin
         errors++;
         $display("FAIL held_head: got valid=%b res=%h allowin=%b, required 1 1111aaaa 0",
                  bus.ms_to_ws_valid, bus.ms_to_ws_result, bus.ms_allowin);
      end
      @(posedge clk); #1;
      bus.data_sram_data_ok = 1'b0;
      #1;
      checks++;
      if (bus.ms_load_pending !== 1'b0) begin
         errors++;
         $display("FAIL captured_both: got pend=%b, required 0", bus.ms_load_pending);
      end
      bus.ws_allowin = 1'b1;
      #1;
      checks++;
      if (bus.ms_allowin !== 1'b1) begin
         errors++;
         $display("FAIL retire_frees_slot: got allowin=%b, required 1", bus.ms_allowin);
      end
      repeat (3) @(posedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got %0d outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_flush();
      issue(3'd0, 2'd0, 32'h0, 1'b1, 1'b1, 5'd20, 32'h0, 0);
      issue(3'd0, 2'd0, 32'h0, 1'b1, 1'b1, 5'd21, 32'h0, 0);
      for (int pass = 0; pass < 2; pass++) begin
         bus.flush = 1'b1;
         #1;
         checks++;
         if (bus.ms_allowin !== 1'b0 || bus.ms_to_ws_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_cycle: got allowin=%b valid=%b, required 0 0", bus.ms_allowin, bus.ms_to_ws_valid);
         end
         @(posedge clk); #1;
         bus.flush = 1'b0;
         bus.es_to_ms_valid = 1'b0;
         #1;
         checks++;
         if (bus.ms_allowin !== 1'b1 || bus.ms_load_pending !== 1'b0 || bus.ms_dest_mask !== 32'd0) begin
            errors++;
            $display("FAIL post_flush: got allowin=%b pend=%b mask=%h, required 1 0 0",
                     bus.ms_allowin, bus.ms_load_pending, bus.ms_dest_mask);
         end
         @(posedge clk); #1;
         bus.data_sram_data_ok = 1'b1;
         bus.data_sram_rdata   = 32'hDEAD_0000;
         for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (bus.ms_to_ws_valid !== 1'b0) begin
               errors++;
               $display("FAIL stale_dropped: got valid=%b, required 0", bus.ms_to_ws_valid);
            end
            @(posedge clk); #1;
         end
         bus.data_sram_data_ok = 1'b0;
         run_load(3'd0, 2'd0, 32'h0, 32'h5A5A_0F0F + pass, 5'd22);
         if (pass == 0) begin
            // second round: one queued load plus a load offered by EX during the flush
            issue(3'd0, 2'd0, 32'h0, 1'b1, 1'b1, 5'd23, 32'h0, 0);
            bus.es_to_ms_valid = 1'b1;
            bus.es_mem_req     = 1'b1;
         end
      end
      @(posedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL flush_drain: got %0d outstanding, required 0", sb.size());
      end
   endtask

   task automatic test_reset_midload();
      issue(3'd0, 2'd0, 32'h0, 1'b1, 1'b1, 5'd25, 32'h0, 0);
      bus.data_sram_data_ok = 1'b1;
      bus.data_sram_rdata   = 32'h1357_9BDF;
      resetn = 1'b0;
      #1;
      checks++;
      if (bus.ms_allowin !== 1'b0 || bus.ms_to_ws_valid !== 1'b0 || bus.ms_to_ws_result !== 32'd0 ||
          bus.ms_dest_mask !== 32'd0 || bus.ms_load_pending !== 1'b0 || bus.ms_to_ws_dest !== 5'd0) begin
         errors++;
         $display("FAIL async_reset: got allowin=%b valid=%b res=%h mask=%h pend=%b dest=%0d, required all 0",
                  bus.ms_allowin, bus.ms_to_ws_valid, bus.ms_to_ws_result, bus.ms_dest_mask,
                  bus.ms_load_pending, bus.ms_to_ws_dest);
      end
      @(posedge clk); #1;
      bus.data_sram_data_ok = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      #1;
      checks++;
      if (bus.ms_allowin !== 1'b1 || bus.ms_to_ws_valid !== 1'b0 || bus.ms_load_pending !== 1'b0) begin
         errors++;
         $display("FAIL reset_empty: got allowin=%b valid=%b pend=%b, required 1 0 0",
                  bus.ms_allowin, bus.ms_to_ws_valid, bus.ms_load_pending);
      end
      @(posedge clk); #1;
      run_load(3'd3, 2'd0, 32'h0, 32'h0000_8001, 5'd26);
      @(posedge clk); #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL reset_drain: got %0d outstanding, required 0", sb.size());
      end
   endtask

   initial begin
      resetn = 1'b0;
      bus.es_to_ms_valid = 1'b0; bus.es_mem_req = 1'b0; bus.es_ld_type = 3'd0; bus.es_ldb = 2'd0;
      bus.es_rt = 32'd0; bus.es_result = 32'd0; bus.es_res_from_mem = 1'b0; bus.es_gr_we = 1'b0;
      bus.es_dest = 5'd0; bus.es_payload = 64'd0; bus.data_sram_data_ok = 1'b0;
      bus.data_sram_rdata = 32'd0; bus.flush = 1'b0; bus.ws_allowin = 1'b1;
      test_reset();
      test_lw_bypass();
      test_ld_types();
      test_back_to_back();
      test_flush();
      test_reset_midload();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
